regfile_port_arbiter: RTL and testbench

//  Shares port b of the 32x8 CPU register file between NREQ requesters, e.g. CPU

---
 rtl/regfile_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing register file port b between NREQ requesters.
// Supports read, write, atomic bit set/clear; writes to PROT_ADDR are rejected.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req/op/addr/wdata     per-requester request bundle (held until ack)
//   ack/err               one-cycle completion / rejection pulse, one-hot
//   rdata                 read or pre-modify value, valid with ack
//   busy                  high whenever the FSM is not idle
//   rf_b_*                register file port b (combinational read)
module regfile_port_arbiter #(
    parameter int          NREQ      = 3,
    parameter logic [4:0]  PROT_ADDR = 5'd31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   op,
    input  logic [5*NREQ-1:0]   addr,
    input  logic [8*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rdata,
    output logic                busy,
    output logic [4:0]          rf_b_addr,
    output logic [7:0]          rf_b_data_in,
    output logic                rf_b_wr_enable,
    input  logic [7:0]          rf_b_data_out
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_RMW_WR,
        S_ACK
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_reg_q, rdata_reg_d;
    logic [7:0]      rdata_hold_q, rdata_hold_d;
    logic            err_q, err_d;

    logic            grant_valid;
    logic [IW-1:0]   grant_idx;
    int              cand;

    // Rotating priority: scan from ptr upward, wrapping, first request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int j = 0; j < NREQ; j++) begin
            cand = int'(ptr_q) + j;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        op_d           = op_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rdata_reg_d    = rdata_reg_q;
        rdata_hold_d   = rdata_hold_q;
        err_d          = err_q;
        rf_b_addr      = 5'd0;
        rf_b_data_in   = 8'd0;
        rf_b_wr_enable = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    op_d    = op[2*grant_idx +: 2];
                    addr_d  = addr[5*grant_idx +: 5];
                    wdata_d = wdata[8*grant_idx +: 8];
                    err_d   = 1'b0;
                    ptr_d   = (int'(grant_idx) == NREQ - 1) ? '0
                              : grant_idx + 1'b1;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                rf_b_addr   = addr_q;
                rdata_reg_d = rf_b_data_out;
                if (op_q == 2'b00) begin
                    state_d = S_ACK;
                end else if (addr_q == PROT_ADDR) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else if (op_q == 2'b01) begin
                    rf_b_wr_enable = 1'b1;
                    rf_b_data_in   = wdata_q;
                    state_d        = S_ACK;
                end else begin
                    state_d = S_RMW_WR;
                end
            end
            S_RMW_WR: begin
                rf_b_addr      = addr_q;
                rf_b_wr_enable = 1'b1;
                // op 10 sets mask bits, op 11 clears them
                rf_b_data_in   = op_q[0] ? (rdata_reg_q & ~wdata_q)
                                         : (rdata_reg_q | wdata_q);
                state_d        = S_ACK;
            end
            S_ACK: begin
                rdata_hold_d = rdata_reg_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            op_q         <= 2'b00;
            addr_q       <= 5'd0;
            wdata_q      <= 8'd0;
            rdata_reg_q  <= 8'd0;
            rdata_hold_q <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_reg_q  <= rdata_reg_d;
            rdata_hold_q <= rdata_hold_d;
            err_q        <= err_d;
        end
    end

    // rdata_reg changes mid-operation; the hold copy keeps rdata stable
    // between acks.
    always_comb begin
        ack   = '0;
        err   = '0;
        rdata = rdata_hold_q;
        if (state_q == S_ACK) begin
            ack   = NREQ'(1) << idx_q;
            err   = err_q ? (NREQ'(1) << idx_q) : '0;
            rdata = rdata_reg_q;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x8 regfile.
// Checks latency, bit ops, protection, round-robin, atomicity and reset.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [5:0]  op;
    logic [14:0] addr;
    logic [23:0] wdata;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic [4:0]  rf_b_addr;
    logic [7:0]  rf_b_data_in;
    logic        rf_b_wr_enable;
    logic [7:0]  rf_b_data_out;

    logic [7:0]  rf_mem [32];

    int total = 0;
    int bad   = 0;

    regfile_port_arbiter #(.NREQ(3), .PROT_ADDR(5'd31)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .op             (op),
        .addr           (addr),
        .wdata          (wdata),
        .ack            (ack),
        .err            (err),
        .rdata          (rdata),
        .busy           (busy),
        .rf_b_addr      (rf_b_addr),
        .rf_b_data_in   (rf_b_data_in),
        .rf_b_wr_enable (rf_b_wr_enable),
        .rf_b_data_out  (rf_b_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_b_wr_enable) rf_mem[rf_b_addr] <= rf_b_data_in;
    end
    assign rf_b_data_out = rf_mem[rf_b_addr];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for ack, then drop req and
    // step to IDLE. we_seen[n] records wr_enable n cycles after issue.
    task automatic do_op(input int r, input logic [1:0] o,
                         input logic [4:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd,
                         output logic [2:0] ak, output logic [2:0] er,
                         output logic [3:0] we_seen);
        req[r]          = 1'b1;
        op[2*r +: 2]    = o;
        addr[5*r +: 5]  = a;
        wdata[8*r +: 8] = d;
        lat     = 0;
        we_seen = 4'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (rf_b_wr_enable && lat <= 3) we_seen[lat] = 1'b1;
        end while (ack == 3'b0 && lat < 20);
        ak = ack;
        er = err;
        rd = rdata;
        req[r] = 1'b0;
        @(posedge clk); #1;
    endtask

    int         lat;
    int         cnt;
    logic [7:0] rd;
    logic [2:0] ak;
    logic [2:0] er;
    logic [3:0] we;
    logic [7:0] rr_rd [3];

    initial begin
        reset = 1'b1;
        req   = '0;
        op    = '0;
        addr  = '0;
        wdata = '0;
        #12;
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_we", rf_b_wr_enable, 0);
        check("rst_baddr", rf_b_addr, 0);
        check("rst_bdin", rf_b_data_in, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // write then read back
        do_op(0, 2'b01, 5'd5, 8'hA5, lat, rd, ak, er, we);
        check("wr_lat", lat, 2);
        check("wr_ack", ak, 3'b001);
        check("wr_err", er, 0);
        check("wr_we_acc", we, 4'b0010);
        check("wr_mem", rf_mem[5], 8'hA5);
        do_op(0, 2'b00, 5'd5, 8'h00, lat, rd, ak, er, we);
        check("rd_lat", lat, 2);
        check("rd_data", rd, 8'hA5);
        check("rd_err", er, 0);
        check("rd_we", we, 0);
        check("rd_hold", rdata, 8'hA5);

        // atomic set / clear
        do_op(1, 2'b01, 5'd7, 8'hF0, lat, rd, ak, er, we);
        check("pre7_mem", rf_mem[7], 8'hF0);
        do_op(1, 2'b10, 5'd7, 8'h0F, lat, rd, ak, er, we);
        check("set_lat", lat, 3);
        check("set_ack", ak, 3'b010);
        check("set_rd", rd, 8'hF0);
        check("set_we", we, 4'b0100);
        check("set_mem", rf_mem[7], 8'hFF);
        do_op(1, 2'b11, 5'd7, 8'h81, lat, rd, ak, er, we);
        check("clr_lat", lat, 3);
        check("clr_rd", rd, 8'hFF);
        check("clr_mem", rf_mem[7], 8'h7E);

        // protected address
        do_op(2, 2'b01, 5'd31, 8'h55, lat, rd, ak, er, we);
        check("prot_lat", lat, 2);
        check("prot_ack", ak, 3'b100);
        check("prot_err", er, 3'b100);
        check("prot_we", we, 0);
        do_op(2, 2'b00, 5'd31, 8'h00, lat, rd, ak, er, we);
        check("prot_rd_ack", ak, 3'b100);
        check("prot_rd_err", er, 0);

        // round robin, all three held
        rr_rd[0] = 8'hA5;
        rr_rd[1] = 8'h7E;
        rr_rd[2] = 8'hA5;
        op    = 6'b0;
        addr  = {5'd5, 5'd7, 5'd5};
        wdata = '0;
        req   = 3'b111;
        for (int g = 0; g < 6; g++) begin
            cnt = 0;
            do begin
                @(posedge clk); #1;
                cnt++;
            end while (ack == 3'b0 && cnt < 10);
            check("rr_grant", ack, 32'd1 << (g % 3));
            check("rr_rdata", rdata, rr_rd[g % 3]);
            if (g == 5) req = 3'b000;
        end
        @(posedge clk); #1;

        // atomicity: write to the same address waits for the set
        do_op(0, 2'b01, 5'd9, 8'h30, lat, rd, ak, er, we);
        req[1]      = 1'b1;
        op[3:2]     = 2'b10;
        addr[9:5]   = 5'd9;
        wdata[15:8] = 8'h0F;
        @(posedge clk); #1;
        req[0]      = 1'b1;
        op[1:0]     = 2'b01;
        addr[4:0]   = 5'd9;
        wdata[7:0]  = 8'h5A;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (ack == 3'b0 && cnt < 10);
        check("atom_first", ack, 3'b010);
        check("atom_rd", rdata, 8'h30);
        check("atom_mid", rf_mem[9], 8'h3F);
        req[1] = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (ack == 3'b0 && cnt < 10);
        check("atom_second", ack, 3'b001);
        check("atom_final", rf_mem[9], 8'h5A);
        req[0] = 1'b0;
        @(posedge clk); #1;

        // reset during RMW_WR
        do_op(0, 2'b01, 5'd7, 8'h3C, lat, rd, ak, er, we);
        req[1]      = 1'b1;
        op[3:2]     = 2'b10;
        addr[9:5]   = 5'd7;
        wdata[15:8] = 8'h03;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmw_we_pre", rf_b_wr_enable, 1);
        check("rmw_busy_pre", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_we", rf_b_wr_enable, 0);
        check("arst_ack", ack, 0);
        check("arst_busy", busy, 0);
        req = '0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("arst_mem", rf_mem[7], 8'h3C);
        check("arst_idle", busy, 0);
        do_op(2, 2'b00, 5'd7, 8'h00, lat, rd, ak, er, we);
        check("post_rst_ack", ak, 3'b100);
        check("post_rst_rd", rd, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
